// File: rtl/range_multi.sv
// Collatz range sweeper: LANES parallel iterators compute sequence lengths for RAM_WORDS
// consecutive start values into on-chip RAM, tracking the maximum and any overflow.
module range_multi #(
    parameter int unsigned N_WIDTH       = 32,
    parameter int unsigned COUNT_BITS    = 16,
    parameter int unsigned RAM_WORDS     = 16,
    parameter int unsigned RAM_ADDR_BITS = 4,
    parameter int unsigned LANES         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [N_WIDTH-1:0]       start,
    output logic                     done,
    output logic                     running,
    output logic [COUNT_BITS-1:0]    count,
    output logic [COUNT_BITS-1:0]    max_count,
    output logic [RAM_ADDR_BITS-1:0] max_index,
    output logic                     ovf
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [RAM_ADDR_BITS:0] WORDS = (RAM_ADDR_BITS + 1)'(RAM_WORDS);
    localparam logic [RAM_ADDR_BITS:0] ONE_A = (RAM_ADDR_BITS + 1)'(1);
    localparam logic [COUNT_BITS-1:0]  ONE_C = COUNT_BITS'(1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                   state_q;
    logic [N_WIDTH-1:0]       base_q;
    logic [RAM_ADDR_BITS:0]   next_idx_q, next_idx_d, written_q;
    logic [LANES-1:0]         busy_q, fin_q;
    logic [N_WIDTH-1:0]       lane_n_q   [LANES];
    logic [COUNT_BITS-1:0]    lane_len_q [LANES];
    logic [RAM_ADDR_BITS-1:0] lane_idx_q [LANES];
    logic [COUNT_BITS-1:0]    mem        [RAM_WORDS];

    // Write-port arbitration: lowest finished lane wins.
    logic                     grant_v;
    logic [LW-1:0]            grant;
    logic [COUNT_BITS-1:0]    wr_len;
    logic [RAM_ADDR_BITS-1:0] wr_idx;

    always_comb begin
        grant_v = 1'b0;
        grant   = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (busy_q[l] && fin_q[l]) begin
                grant_v = 1'b1;
                grant   = LW'(l);
            end
        end
        wr_len = lane_len_q[grant];
        wr_idx = lane_idx_q[grant];
    end

    // Dispatch: idle lanes take consecutive indices, lowest lane first.
    logic [LANES-1:0]         disp;
    logic [RAM_ADDR_BITS-1:0] disp_idx [LANES];
    logic [N_WIDTH-1:0]       disp_n   [LANES];

    always_comb begin
        next_idx_d = next_idx_q;
        disp       = '0;
        for (int l = 0; l < LANES; l++) begin
            disp_idx[l] = next_idx_d[RAM_ADDR_BITS-1:0];
            disp_n[l]   = base_q + N_WIDTH'(next_idx_d[RAM_ADDR_BITS-1:0]);
            if (!busy_q[l] && (next_idx_d < WORDS)) begin
                disp[l]    = 1'b1;
                next_idx_d = next_idx_d + ONE_A;
            end
        end
    end

    // One Collatz step per busy lane; 3n+1 is computed two bits wider to catch overflow.
    logic [N_WIDTH-1:0]    step_n   [LANES];
    logic [COUNT_BITS-1:0] step_len [LANES];
    logic [LANES-1:0]      step_fin, step_ovf;
    logic [N_WIDTH+1:0]    n3p1;

    always_comb begin
        step_fin = '0;
        step_ovf = '0;
        n3p1     = '0;
        for (int l = 0; l < LANES; l++) begin
            step_n[l]   = lane_n_q[l];
            step_len[l] = lane_len_q[l];
            n3p1 = {2'b00, lane_n_q[l]} + {1'b0, lane_n_q[l], 1'b0} + (N_WIDTH + 2)'(1);
            if (lane_n_q[l] <= N_WIDTH'(1)) begin
                step_fin[l] = 1'b1;
            end else if (!lane_n_q[l][0]) begin
                step_n[l]   = lane_n_q[l] >> 1;
                step_len[l] = lane_len_q[l] + ONE_C;
                step_fin[l] = &step_len[l];
            end else if (n3p1[N_WIDTH+1:N_WIDTH] != 2'b00) begin
                step_ovf[l] = 1'b1;
                step_len[l] = '1;
                step_fin[l] = 1'b1;
            end else begin
                step_n[l]   = n3p1[N_WIDTH-1:0];
                step_len[l] = lane_len_q[l] + ONE_C;
                step_fin[l] = &step_len[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            running    <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            max_count  <= '0;
            max_index  <= '0;
            ovf        <= 1'b0;
            base_q     <= '0;
            next_idx_q <= '0;
            written_q  <= '0;
            busy_q     <= '0;
            fin_q      <= '0;
            for (int l = 0; l < LANES; l++) begin
                lane_n_q[l]   <= '0;
                lane_len_q[l] <= '0;
                lane_idx_q[l] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    count <= mem[start[RAM_ADDR_BITS-1:0]];
                    if (go) begin
                        state_q    <= StRun;
                        running    <= 1'b1;
                        done       <= 1'b0;
                        max_count  <= '0;
                        max_index  <= '0;
                        ovf        <= 1'b0;
                        base_q     <= start;
                        next_idx_q <= '0;
                        written_q  <= '0;
                        busy_q     <= '0;
                        fin_q      <= '0;
                    end
                end
                StRun: begin
                    if (written_q == WORDS) begin
                        state_q <= StIdle;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        next_idx_q <= next_idx_d;
                        for (int l = 0; l < LANES; l++) begin
                            if (grant_v && (grant == LW'(l))) begin
                                busy_q[l] <= 1'b0;
                                fin_q[l]  <= 1'b0;
                            end else if (disp[l]) begin
                                busy_q[l]     <= 1'b1;
                                lane_idx_q[l] <= disp_idx[l];
                                lane_n_q[l]   <= disp_n[l];
                                // Zero has length 0 and is ready to write at once.
                                lane_len_q[l] <= (disp_n[l] == '0) ? '0 : ONE_C;
                                fin_q[l]      <= (disp_n[l] == '0);
                            end else if (busy_q[l] && !fin_q[l]) begin
                                lane_n_q[l]   <= step_n[l];
                                lane_len_q[l] <= step_len[l];
                                fin_q[l]      <= step_fin[l];
                            end
                        end
                        if (|(step_ovf & busy_q & ~fin_q)) begin
                            ovf <= 1'b1;
                        end
                        if (grant_v) begin
                            written_q <= written_q + ONE_A;
                            if ((wr_len > max_count) ||
                                ((wr_len == max_count) && (wr_idx < max_index))) begin
                                max_count <= wr_len;
                                max_index <= wr_idx;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == StRun) && grant_v) begin
            mem[wr_idx] <= wr_len;
        end
    end

endmodule

// File: tb/tb_range_multi.sv
// Scoreboard bench for range_multi: four- and one-lane 32-bit instances plus an 8-bit instance.
module tb_range_multi;

    logic        clk = 1'b0;
    logic        reset, go, go8;
    logic [31:0] start;
    logic [7:0]  start8;

    logic        done4, run4, ovf4, done1, run1, ovf1, done8, run8, ovf8;
    logic [15:0] cnt4, max4, cnt1, max1, cnt8, max8;
    logic [3:0]  mi4, mi1, mi8;

    always #5 clk = ~clk;

    range_multi #(.LANES(4)) u4 (
        .clk(clk), .reset(reset), .go(go), .start(start), .done(done4), .running(run4),
        .count(cnt4), .max_count(max4), .max_index(mi4), .ovf(ovf4)
    );
    range_multi #(.LANES(1)) u1 (
        .clk(clk), .reset(reset), .go(go), .start(start), .done(done1), .running(run1),
        .count(cnt1), .max_count(max1), .max_index(mi1), .ovf(ovf1)
    );
    range_multi #(.N_WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .go(go8), .start(start8), .done(done8), .running(run8),
        .count(cnt8), .max_count(max8), .max_index(mi8), .ovf(ovf8)
    );

    typedef struct {
        int          sel;
        int          due;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pick(input int s);
        case (s)
            0:  return cnt4;
            1:  return cnt1;
            2:  return max4;
            3:  return {12'h0, mi4};
            4:  return {15'h0, ovf4};
            5:  return max1;
            6:  return {12'h0, mi1};
            7:  return cnt8;
            8:  return {15'h0, ovf8};
            9:  return {15'h0, run4};
            10: return {15'h0, done4};
            11: return {15'h0, ovf1};
            12: return {15'h0, run1};
            13: return max8;
            14: return {12'h0, mi8};
            15: return {15'h0, run8};
            16: return {15'h0, done1};
            default: return {15'h0, done8};
        endcase
    endfunction

    // Monitor: compares every expectation whose due cycle has arrived.
    initial begin
        chk_t        c;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                c   = q.pop_front();
                act = pick(c.sel);
                total++;
                if (act !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got %0h want %0h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic push(input int sel, input int due, input logic [15:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.due  = due;
        c.exp  = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic readback(input int sel, input int addr, input logic [15:0] exp,
                            input string name);
        @(negedge clk);
        start  = 32'(addr);
        start8 = 8'(addr);
        push(sel, cyc + 1, exp, name);
    endtask

    task automatic sweep(input logic [31:0] s);
        @(negedge clk);
        start = s;
        go    = 1'b1;
        @(negedge clk);
        go    = 1'b0;
    endtask

    int t4, t1;

    task automatic wait_done();
        int n;
        n  = 0;
        t4 = -1;
        t1 = -1;
        while (!(done4 && done1) && n < 4000) begin
            @(negedge clk);
            n++;
            if (done4 && t4 < 0) t4 = n;
            if (done1 && t1 < 0) t1 = n;
        end
        if (!(done4 && done1)) begin
            total++;
            bad++;
            $display("FAIL sweep_timeout: got done4=%0b done1=%0b want 1 1", done4, done1);
        end
    endtask

    logic [15:0] len1 [16] = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd6, 16'd9, 16'd17, 16'd4,
                               16'd20, 16'd7, 16'd15, 16'd10, 16'd10, 16'd18, 16'd18, 16'd5};

    initial begin
        int n;
        reset  = 1'b1;
        go     = 1'b0;
        go8    = 1'b0;
        start  = '0;
        start8 = '0;
        repeat (2) @(negedge clk);
        push(9, cyc, 16'd0, "rst_running");
        push(10, cyc, 16'd0, "rst_done");
        push(0, cyc, 16'd0, "rst_count");
        push(2, cyc, 16'd0, "rst_max_count");
        push(3, cyc, 16'd0, "rst_max_index");
        push(4, cyc, 16'd0, "rst_ovf");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // start=1: full image compared on both lane counts.
        sweep(32'd1);
        push(9, cyc, 16'd1, "running_during_sweep");
        wait_done();
        total++;
        if (!(t4 > 0 && t4 < t1)) begin
            bad++;
            $display("FAIL lanes4_faster: got t4=%0d t1=%0d want t4<t1", t4, t1);
        end
        push(2, cyc, 16'd20, "s1_max_count4");
        push(3, cyc, 16'd8, "s1_max_index4");
        push(4, cyc, 16'd0, "s1_ovf4");
        push(5, cyc, 16'd20, "s1_max_count1");
        push(6, cyc, 16'd8, "s1_max_index1");
        push(11, cyc, 16'd0, "s1_ovf1");
        push(12, cyc, 16'd0, "s1_running1");
        push(16, cyc, 16'd1, "s1_done1");
        for (int a = 0; a < 16; a++) begin
            readback(0, a, len1[a], $sformatf("s1_lanes4_addr%0d", a));
            push(1, cyc + 1, len1[a], $sformatf("s1_lanes1_addr%0d", a));
        end

        // start=0 with a stray go mid-sweep that must be ignored.
        sweep(32'd0);
        repeat (5) @(negedge clk);
        start = 32'd7;
        go    = 1'b1;
        @(negedge clk);
        go    = 1'b0;
        wait_done();
        readback(0, 0, 16'd0, "s0_addr0");
        readback(0, 1, 16'd1, "s0_addr1");
        readback(1, 9, 16'd20, "s0_lanes1_addr9");
        push(2, cyc, 16'd20, "s0_max_count");
        push(3, cyc, 16'd9, "s0_max_index");

        // start=12: 12 and 13 tie at 10, 27 dominates at offset 15.
        sweep(32'd12);
        wait_done();
        readback(0, 0, 16'd10, "s12_addr0");
        readback(0, 1, 16'd10, "s12_addr1");
        readback(0, 15, 16'd112, "s12_addr15");
        push(2, cyc, 16'd112, "s12_max_count");
        push(3, cyc, 16'd15, "s12_max_index");

        // start=4: 18 and 19 both reach the maximum 21; smaller offset wins.
        sweep(32'd4);
        wait_done();
        readback(0, 14, 16'd21, "s4_addr14");
        readback(1, 15, 16'd21, "s4_lanes1_addr15");
        push(2, cyc, 16'd21, "s4_max_count4");
        push(3, cyc, 16'd14, "s4_max_index4");
        push(5, cyc, 16'd21, "s4_max_count1");
        push(6, cyc, 16'd14, "s4_max_index1");

        // 8-bit datapath: 27 overflows at 3*107+1.
        @(negedge clk);
        start8 = 8'd27;
        go8    = 1'b1;
        @(negedge clk);
        go8    = 1'b0;
        n = 0;
        while (!done8 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        push(17, cyc, 16'd1, "w8_done");
        push(8, cyc, 16'd1, "w8_ovf");
        push(15, cyc, 16'd0, "w8_running");
        push(13, cyc, 16'hFFFF, "w8_max_count");
        push(14, cyc, 16'd0, "w8_max_index");
        readback(7, 0, 16'hFFFF, "w8_addr0");
        readback(7, 1, 16'd19, "w8_addr1");

        // Asynchronous reset in the middle of a sweep, then a clean rerun.
        sweep(32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        push(9, cyc, 16'd0, "abort_running");
        push(10, cyc, 16'd0, "abort_done");
        push(2, cyc, 16'd0, "abort_max_count");
        push(3, cyc, 16'd0, "abort_max_index");
        @(negedge clk);
        #1 reset = 1'b0;
        sweep(32'd1);
        wait_done();
        push(10, cyc, 16'd1, "rerun_done");
        push(2, cyc, 16'd20, "rerun_max_count");
        push(3, cyc, 16'd8, "rerun_max_index");
        readback(0, 8, 16'd20, "rerun_addr8");
        readback(1, 2, 16'd8, "rerun_lanes1_addr2");

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/range_multi.md
Name: range_multi

Overview:
- Parametrised successor to the single-iterator Collatz range sweeper.
- On a go pulse it computes Collatz sequence lengths for RAM_WORDS consecutive start values, using LANES internal iterators in parallel, and stores the results in on-chip RAM.
- It also tracks the running maximum and flags arithmetic overflow.
- When idle, the RAM is read back through the same start/count interface.

Parameters:
- N_WIDTH, 32: width of start value and iterator datapath.
- COUNT_BITS, 16: width of stored sequence length.
- RAM_WORDS, 16: number of results stored.
- RAM_ADDR_BITS, 4: log2(RAM_WORDS); RAM_WORDS must equal 2**RAM_ADDR_BITS.
- LANES, 4: number of parallel iterators, 1..RAM_WORDS.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- go  in  1  one-cycle start pulse, sampled when idle
- start  in  N_WIDTH  base value on go; when idle, low RAM_ADDR_BITS form the read address
- done  out  1  sweep complete, results valid
- running  out  1  sweep in progress
- count  out  COUNT_BITS  RAM read data, registered
- max_count  out  COUNT_BITS  largest length written in the current sweep
- max_index  out  RAM_ADDR_BITS  offset (address) of max_count
- ovf  out  1  sticky: some iteration overflowed N_WIDTH

Behaviour:
- Reset (async, active-high): running=0, done=0, count=0, max_count=0, max_index=0, ovf=0, all lanes idle, index counter=0. RAM contents are not cleared.
- Length definition: number of terms including start and the final 1.
  - n=1 -> 1, n=2 -> 2, n=3 -> 8, n=9 -> 20.
  - n=0 -> 0, written immediately with no iteration.
- States: IDLE -> RUN -> IDLE.
- IDLE, go=1:
  - latch base=start; clear done, max_count, max_index, ovf; next_index=0; running=1 from the next cycle.
- RUN, lane dispatch:
  - An idle lane takes next_index and loads n=base+next_index, length=1.
  - Same cycle, next_index increments.
  - Several idle lanes are served in one cycle, lowest lane first.
  - base+index wraps modulo 2**N_WIDTH.
- RUN, lane step (one per cycle):
  - If n==1 (or n==0): finished.
  - Else n <= n even ? n>>1 : 3n+1, and length increments.
  - If 3n+1 exceeds 2**N_WIDTH-1: ovf=1, length forced to all-ones, lane finishes.
  - If length reaches all-ones: saturate and finish.
- Write port: one RAM write per cycle.
  - Finished lanes arbitrate with fixed priority, lowest lane index first.
  - The winner writes mem[index] <= length; losers hold their result.
  - A granted lane becomes idle and may be dispatched again the following cycle.
- Max tracking, on each write:
  - If length > max_count, or (length == max_count and index < max_index), update both.
  - Result is deterministic regardless of completion order.
- Completion:
  - When all RAM_WORDS results are written, running=0 and done=1 on the next edge.
  - done stays high until the next accepted go or reset.
- go while running: ignored.
- go in the same cycle done rises: not possible; done rises only once running has dropped, and go is only sampled in IDLE.
- Readback:
  - While running=0, count <= mem[start[RAM_ADDR_BITS-1:0]] every cycle (1-cycle latency).
  - While running=1, count holds its value.
- Reset mid-sweep: immediate abort. RAM partially updated (contents unspecified); outputs take reset values.
- LANES=1 must produce identical RAM contents and max outputs to LANES=4.

Test Plan:
- Reset, then go with start=1 (defaults) -> done after completion. Readback:
  - addr0=1, addr1=2, addr2=8, addr8=20, addr15=5.
  - max_count=20, max_index=8, ovf=0.
- Same sweep with LANES=1 and LANES=4 -> identical RAM image and max outputs. LANES=4 finishes in fewer cycles.
- start=0 -> addr0=0, addr1=1. go pulsed again mid-sweep -> ignored; results unchanged.
- N_WIDTH=8, start=27 -> ovf=1 and addr0=16'hFFFF.
- Tie ordering: start=12 sweep -> among equal lengths, max_index reports the smallest offset. Example: 12 and 13 both have length 10, first max beyond that is checked against a software model.
- Assert reset for 1 cycle mid-sweep -> running, done and max outputs go to 0 asynchronously. A new go then completes normally with correct results.
